// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Purpose  : Shared types and constants for the FFT peak reader slice.
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

  localparam int FFT_N     = 512;
  localparam int FFT_LOG2N = 9;

  typedef logic [FFT_LOG2N-1:0] bin_idx_t;
  typedef logic [31:0]          mag_t;
  typedef logic [30:0]          sq_t;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } fft_word_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SKIP    = 3'd1,
    S_SCAN    = 3'd2,
    S_FLUSH   = 3'd3,
    S_HOLD    = 3'd4,
    S_RESTART = 3'd5
  } scan_state_t;

  // Mirror the bit order of a bin index (bit-reversed stream addressing).
  function automatic bin_idx_t bitrev_idx(input bin_idx_t k);
    bin_idx_t r;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = k[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_mag_sq.sv
`default_nettype none
// ============================================================================
//  Module   : fft_mag_sq
//  Purpose  : Registered squarer. Squares the real and imaginary parts of one
//             FFT word and passes the bin index alongside; 1-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic      slow_clk,
  input  logic      reset,
  input  logic      valid_i,
  input  fft_word_t word_i,
  input  bin_idx_t  idx_i,
  output logic      valid_o,
  output sq_t       re_sq_o,
  output sq_t       im_sq_o,
  output bin_idx_t  idx_o
);

  // Magnitudes as unsigned 16-bit values; -32768 maps to 32768 exactly,
  // so each square is at most 2^30 and fits in 31 bits.
  logic [15:0] abs_re_w;
  logic [15:0] abs_im_w;
  sq_t         re_sq_w;
  sq_t         im_sq_w;

  logic        valid_q;
  sq_t         re_sq_q;
  sq_t         im_sq_q;
  bin_idx_t    idx_q;

  assign abs_re_w = word_i.re[15] ? (16'd0 - word_i.re) : word_i.re;
  assign abs_im_w = word_i.im[15] ? (16'd0 - word_i.im) : word_i.im;
  assign re_sq_w  = {15'd0, abs_re_w} * {15'd0, abs_re_w};
  assign im_sq_w  = {15'd0, abs_im_w} * {15'd0, abs_im_w};

  // Square stage register: squares, index and qualifier advance together.
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      re_sq_q <= '0;
      im_sq_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_i;
      re_sq_q <= re_sq_w;
      im_sq_q <= im_sq_w;
      idx_q   <= idx_i;
    end
  end

  assign valid_o = valid_q;
  assign re_sq_o = re_sq_q;
  assign im_sq_o = im_sq_q;
  assign idx_o   = idx_q;

endmodule
`default_nettype wire

// File: rtl/fft_peak_reader.sv
`default_nettype none
// ============================================================================
//  Module   : fft_peak_reader
//  Purpose  : Walks the FFT result stream after done, finds the largest
//             |X[k]|^2 inside [MIN_BIN, MAX_BIN], offers {peak_bin, peak_mag}
//             over valid/ready and then pulses fft_restart.
//             Optional build macro FFT_PEAK_BITREV_EN: stream is treated as
//             bit-reversed and all N words are scanned.
//  Revision : 1.0  initial release
// ============================================================================
module fft_peak_reader
  import fft_pkg::*;
#(
  parameter int unsigned N            = 512,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MIN_BIN      = 1,
  parameter int unsigned MAX_BIN      = 255
) (
  input  logic        slow_clk,
  input  logic        reset,
  input  logic        fft_done,
  input  logic [31:0] fft_data,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [8:0]  peak_bin,
  output logic [31:0] peak_mag,
  output logic        fft_restart,
  output logic        scan_abort
);

  localparam int       SKIP_W    = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
  localparam bin_idx_t C_MIN     = bin_idx_t'(MIN_BIN);
  localparam bin_idx_t C_MAX     = bin_idx_t'(MAX_BIN);
  localparam bin_idx_t C_END     = bin_idx_t'(N - 1);
`ifdef FFT_PEAK_BITREV_EN
  localparam bin_idx_t C_LAST    = C_END;
`else
  localparam bin_idx_t C_LAST    = C_MAX;
`endif

  scan_state_t       state_q, state_d;
  bin_idx_t          k_q, k_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              flush_q, flush_d;
  logic              armed_q, armed_d;
  logic              abort_q, abort_d;
  mag_t              best_mag_q, best_mag_d;
  bin_idx_t          best_bin_q, best_bin_d;
  mag_t              peak_mag_q, peak_mag_d;
  bin_idx_t          peak_bin_q, peak_bin_d;

  logic              cap_en_w;
  bin_idx_t          cap_idx_w;
  logic              last_w;
  logic              sq_valid_w;
  sq_t               re_sq_w;
  sq_t               im_sq_w;
  bin_idx_t          sq_idx_w;
  mag_t              mag_w;
  logic              in_win_w;
  logic              better_w;

`ifdef FFT_PEAK_BITREV_EN
  assign cap_idx_w = bitrev_idx(k_q);
`else
  assign cap_idx_w = k_q;
`endif

  // The final stream word is never past N-1 even if the window says otherwise.
  assign last_w = (k_q == C_LAST) || (k_q == C_END);

  fft_mag_sq u_sq (
    .slow_clk (slow_clk),
    .reset    (reset),
    .valid_i  (cap_en_w),
    .word_i   (fft_word_t'(fft_data)),
    .idx_i    (cap_idx_w),
    .valid_o  (sq_valid_w),
    .re_sq_o  (re_sq_w),
    .im_sq_o  (im_sq_w),
    .idx_o    (sq_idx_w)
  );

  // Compare stage inputs: the sum of two squares peaks at 2^31, no overflow.
  assign mag_w    = {1'b0, re_sq_w} + {1'b0, im_sq_w};
  assign in_win_w = (sq_idx_w >= C_MIN) && (sq_idx_w <= C_MAX);
`ifdef FFT_PEAK_BITREV_EN
  // Stream order differs from index order here, so resolve ties explicitly.
  assign better_w = sq_valid_w && in_win_w &&
                    ((mag_w > best_mag_q) ||
                     ((mag_w == best_mag_q) && (sq_idx_w < best_bin_q)));
`else
  assign better_w = sq_valid_w && in_win_w && (mag_w > best_mag_q);
`endif

  // State and datapath registers.
  always_ff @(posedge slow_clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      skip_q     <= '0;
      flush_q    <= 1'b0;
      armed_q    <= 1'b1;
      abort_q    <= 1'b0;
      best_mag_q <= '0;
      best_bin_q <= '0;
      peak_mag_q <= '0;
      peak_bin_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      skip_q     <= skip_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      abort_q    <= abort_d;
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
      peak_mag_q <= peak_mag_d;
      peak_bin_q <= peak_bin_d;
    end
  end

  // Next-state, capture control and running-maximum update.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    skip_d     = skip_q;
    flush_d    = flush_q;
    armed_d    = armed_q | ~fft_done;
    abort_d    = 1'b0;
    peak_mag_d = peak_mag_q;
    peak_bin_d = peak_bin_q;
    cap_en_w   = 1'b0;
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;

    if (better_w) begin
      best_mag_d = mag_w;
      best_bin_d = sq_idx_w;
    end

    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (fft_done && armed_q) begin
          best_mag_d = '0;
          best_bin_d = '0;
          if (READ_LATENCY == 0) begin
            cap_en_w = 1'b1;
            k_d      = k_q + 1'b1;
            flush_d  = 1'b0;
            state_d  = last_w ? S_FLUSH : S_SCAN;
          end else begin
            skip_d  = SKIP_W'(1);
            state_d = S_SKIP;
          end
        end
      end
      S_SKIP: begin
        if (!fft_done) begin
          abort_d = 1'b1;
          k_d     = '0;
          state_d = S_IDLE;
        end else if (skip_q == SKIP_W'(READ_LATENCY)) begin
          cap_en_w = 1'b1;
          k_d      = k_q + 1'b1;
          flush_d  = 1'b0;
          state_d  = last_w ? S_FLUSH : S_SCAN;
        end else begin
          skip_d = skip_q + 1'b1;
        end
      end
      S_SCAN: begin
        if (!fft_done) begin
          abort_d = 1'b1;
          k_d     = '0;
          state_d = S_IDLE;
        end else begin
          cap_en_w = 1'b1;
          k_d      = k_q + 1'b1;
          if (last_w) begin
            flush_d = 1'b0;
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!flush_q) begin
          flush_d = 1'b1;
        end else begin
          peak_mag_d = best_mag_q;
          peak_bin_d = best_bin_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          state_d = S_RESTART;
        end
      end
      S_RESTART: begin
        // Only a low sample from here on re-arms the next frame.
        armed_d = ~fft_done;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result_valid = (state_q == S_HOLD);
  assign fft_restart  = (state_q == S_RESTART);
  assign scan_abort   = abort_q;
  assign peak_bin     = peak_bin_q;
  assign peak_mag     = peak_mag_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_peak_reader
//  Purpose  : Self-checking bench for fft_peak_reader with a reference model
//             that finds the peak by direct arithmetic over the frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_peak_reader;

  localparam int N    = 512;
  localparam int RL   = 1;
  localparam int MINB = 1;
  localparam int MAXB = 255;
`ifdef FFT_PEAK_BITREV_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif
  localparam int NWORDS    = BR ? N : MAXB + 1;
  localparam int LAST_EDGE = BR ? RL + N + 1 : RL + MAXB + 2;

  logic        slow_clk = 1'b0;
  logic        reset;
  logic        fft_done;
  logic [31:0] fft_data;
  logic        result_valid;
  logic        result_ready;
  logic [8:0]  peak_bin;
  logic [31:0] peak_mag;
  logic        fft_restart;
  logic        scan_abort;

  int     fre [N];
  int     fim [N];
  int     passed = 0;
  int     total  = 0;
  int     exp_bin;
  longint exp_mag;

  fft_peak_reader #(.N(N), .READ_LATENCY(RL), .MIN_BIN(MINB), .MAX_BIN(MAXB)) dut (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .fft_done     (fft_done),
    .fft_data     (fft_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .fft_restart  (fft_restart),
    .scan_abort   (scan_abort)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rev9(input int v);
    int r = 0;
    for (int b = 0; b < 9; b++) if ((v >> b) & 1) r = r | (1 << (8 - b));
    return r;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < N; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  // Reference: magnitude per reported index, then the first strict maximum in
  // ascending index order over the window.
  task automatic model();
    longint m [N];
    int     idx;
    for (int i = 0; i < N; i++) m[i] = 0;
    for (int p = 0; p < NWORDS; p++) begin
      idx    = BR ? rev9(p) : p;
      m[idx] = longint'(fre[p]) * fre[p] + longint'(fim[p]) * fim[p];
    end
    exp_bin = 0;
    exp_mag = 0;
    for (int i = MINB; i <= MAXB; i++) begin
      if (m[i] > exp_mag) begin
        exp_mag = m[i];
        exp_bin = i;
      end
    end
  endtask

  function automatic logic [31:0] word_at(input int p);
    logic [31:0] w;
    w[31:16] = fre[p][15:0];
    w[15:0]  = fim[p][15:0];
    return w;
  endfunction

  // Streams a frame; bin k is presented for edge RL+k, edge 0 = done rising.
  task automatic run_to_valid(input string tag);
    int early = 0;
    model();
    fft_done = 1'b0;
    fft_data = '0;
    tick();
    tick();
    for (int e = 0; e <= LAST_EDGE; e++) begin
      fft_data = (e >= RL && e - RL < NWORDS) ? word_at(e - RL) : 32'd0;
      fft_done = 1'b1;
      tick();
      if (e < LAST_EDGE && (result_valid || scan_abort)) early++;
    end
    fft_data = '0;
    chk({tag, " early_valid"}, early, 0);
    chk({tag, " valid"}, result_valid, 1);
    chk({tag, " peak_bin"}, peak_bin, exp_bin);
    chk({tag, " peak_mag"}, peak_mag, exp_mag);
  endtask

  task automatic watch_idle(input string tag, input int cycles);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (result_valid || fft_restart || scan_abort) bad++;
    end
    chk({tag, " quiet"}, bad, 0);
  endtask

  task automatic accept(input string tag, input int delay);
    int unstable = 0;
    if (!result_ready) begin
      for (int i = 0; i < delay; i++) begin
        tick();
        if (!result_valid || peak_bin !== exp_bin[8:0] || peak_mag !== exp_mag[31:0]
            || fft_restart) unstable++;
      end
      chk({tag, " hold_stable"}, unstable, 0);
      result_ready = 1'b1;
    end
    tick();
    chk({tag, " valid_cleared"}, result_valid, 0);
    chk({tag, " restart_pulse"}, fft_restart, 1);
    result_ready = 1'b0;
    tick();
    chk({tag, " restart_width"}, fft_restart, 0);
    watch_idle({tag, " no_rescan"}, 300);
    fft_done = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    fft_done     = 1'b0;
    fft_data     = '0;
    result_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("rst valid", result_valid, 0);
    chk("rst bin", peak_bin, 0);
    chk("rst mag", peak_mag, 0);
    chk("rst restart", fft_restart, 0);
    chk("rst abort", scan_abort, 0);
    reset = 1'b0;

    // Single peak, ready already high before valid.
    clear_frame();
    fre[37] = 1000;
    fim[37] = -500;
    result_ready = 1'b1;
    run_to_valid("single");
    accept("single", 0);

    // DC and out-of-window bins must be ignored.
    clear_frame();
    fre[0]   = 32767;
    fre[300] = 20000;
    fre[12]  = 100;
    fim[12]  = 100;
    run_to_valid("window");
    accept("window", 2);

    // Equal extreme magnitudes: lower index wins, full 2^31 magnitude.
    clear_frame();
    fre[50] = -32768; fim[50] = -32768;
    fre[60] = -32768; fim[60] = -32768;
    run_to_valid("tie");
    accept("tie", 1);

    // Backpressure for 10 cycles.
    clear_frame();
    fre[200] = 1234;
    fim[200] = 4321;
    run_to_valid("bp");
    accept("bp", 10);

    // Randomized frames.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        fre[i] = int'($signed(16'($urandom)));
        fim[i] = int'($signed(16'($urandom)));
      end
      run_to_valid("rand");
      accept("rand", int'($urandom_range(0, 5)));
    end

    // Abort: done drops at the edge that would capture bin 100.
    for (int i = 0; i < N; i++) begin
      fre[i] = int'($signed(16'($urandom)));
      fim[i] = int'($signed(16'($urandom)));
    end
    fft_done = 1'b0;
    tick();
    for (int e = 0; e < RL + 100; e++) begin
      fft_data = (e >= RL) ? word_at(e - RL) : 32'd0;
      fft_done = 1'b1;
      tick();
    end
    fft_done = 1'b0;
    tick();
    chk("abort pulse", scan_abort, 1);
    chk("abort valid", result_valid, 0);
    tick();
    chk("abort width", scan_abort, 0);
    watch_idle("abort", 300);

    // Reset during HOLD drops the result without a restart pulse.
    clear_frame();
    fre[77] = 555;
    run_to_valid("rsthold");
    tick();
    reset    = 1'b1;
    fft_done = 1'b0;
    tick();
    chk("rsthold valid", result_valid, 0);
    chk("rsthold bin", peak_bin, 0);
    chk("rsthold mag", peak_mag, 0);
    chk("rsthold restart", fft_restart, 0);
    reset = 1'b0;
    watch_idle("rsthold", 20);

`ifdef FFT_PEAK_BITREV_EN
    clear_frame();
    fre[9'h102] = 3000;
    fim[9'h102] = -77;
    run_to_valid("bitrev");
    chk("bitrev bin129", peak_bin, 129);
    accept("bitrev", 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_peak_reader.md
Name: fft_peak_reader

Overview:
- Consumer end of the FFT result stream.
- After the FFT core raises done, this block walks the streamed output words and computes |X[k]|² per bin.
- Tracks the largest-magnitude bin within a configured search window and presents {peak_bin, peak_mag} to the tuner logic through a valid/ready handshake.
- Then pulses a restart request so the FFT core can be reset for the next frame.

Parameters:
- N, 512, FFT length (bins streamed per frame)
- READ_LATENCY, 1, slow_clk cycles from a done-high edge to the matching bin word on fft_data
- MIN_BIN, 1, lowest bin index searched (skips DC)
- MAX_BIN, 255, highest bin index searched (first half of spectrum)

Ports:
- slow_clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- fft_done  in  1  FFT core done level; result words stream while high
- fft_data  in  32  bin word: [31:16] real, [15:0] imag, both signed two's complement
- result_valid  out  1  peak result available
- result_ready  in  1  downstream accepts result
- peak_bin  out  9  index of maximum-magnitude bin
- peak_mag  out  32  unsigned re²+im² of that bin
- fft_restart  out  1  one-cycle pulse requesting FFT core reset
- scan_abort  out  1  one-cycle pulse: fft_done fell mid-scan

Behaviour:
- Reset: all outputs 0, state IDLE, bin counter 0, best_mag 0, best_bin 0.
- FSM states: IDLE, SKIP, SCAN, FLUSH, HOLD, RESTART.
- IDLE -> SKIP on the first edge with fft_done sampled high (edge 0). This edge also clears best_mag/best_bin.
- SKIP:
  - Counts READ_LATENCY edges, then enters SCAN.
  - If READ_LATENCY=0, IDLE goes directly to SCAN.
- SCAN:
  - Each edge captures fft_data as bin k (k = 0..N-1, 9-bit counter).
  - Registers re², im² and k into the square stage (1 cycle).
  - After k = MAX_BIN is captured (natural order), -> FLUSH.
- Compare stage (one cycle after square stage):
  - mag = re²+im², 32-bit unsigned. Max value 2^31, no overflow.
  - If MIN_BIN ≤ k ≤ MAX_BIN and mag > best_mag (strict), update best_mag and best_bin.
  - Ties keep the lower index.
- FLUSH:
  - Waits 2 edges for the pipeline to drain.
  - On the 2nd edge loads peak_bin/peak_mag, sets result_valid=1, -> HOLD.
  - Net timing: result_valid first high after edge READ_LATENCY+MAX_BIN+2.
- HOLD:
  - peak_bin/peak_mag stable while result_valid=1.
  - When result_valid & result_ready are both high at an edge, clear result_valid and -> RESTART.
  - result_ready high before valid has no effect.
  - result_ready held high is accepted on the first valid cycle.
- RESTART: fft_restart=1 for exactly one cycle, then -> IDLE.
- IDLE ignores fft_done until it has been sampled low at least once after RESTART. This prevents rescanning a stale done level.
- fft_done low during SKIP/SCAN: pulse scan_abort for one cycle, discard partial results, -> IDLE. No result_valid, no fft_restart.
- fft_done low during FLUSH/HOLD/RESTART: ignored.
- Bin counter wrap (k reaching N-1) only occurs in BITREV_EN builds. Scan always ends at or before k = N-1.
- Reset mid-operation: immediate return to reset state. Any in-flight result is dropped and no restart pulse is issued.

Optional Feature:
- Macro FFT_PEAK_BITREV_EN.
- Defined:
  - Stream order is treated as bit-reversed. Reported index = 9-bit bit-reverse of k.
  - The window test and peak_bin use the reversed index.
  - SCAN runs all N words (k = 0..N-1) before FLUSH.
  - result_valid first high after edge READ_LATENCY+N+1.
- Undefined: natural order; behaviour as above.

Decomposition:
- Package fft_pkg holds:
  - constants FFT_N=512, FFT_LOG2N=9
  - typedef bin_idx_t (logic [8:0])
  - typedef fft_word_t (struct: signed [15:0] re, signed [15:0] im)
  - typedef mag_t (logic [31:0])
- Sub-module fft_mag_sq: registered squarer, fft_word_t in, two 31-bit squares plus pass-through index out, 1-cycle latency.

Test Plan:
- Single peak: bin 37 = {re=1000, im=-500}, all others 0, result_ready=1 → peak_bin=37, peak_mag=1,250,000. fft_restart pulses one cycle after acceptance.
- Window/DC exclusion: bin 0 = {32767,0}, bin 300 = {20000,0}, bin 12 = {100,100} → peak_bin=12, peak_mag=20000.
- Tie and extreme: bins 50 and 60 = {-32768,-32768}, others 0 → peak_bin=50, peak_mag=2,147,483,648 (0x8000_0000, no overflow).
- Backpressure: result_ready low for 10 cycles after valid → outputs stable for 10 cycles. Handshake on cycle 11, then fft_restart pulse. fft_done held high afterwards → no rescan until it drops.
- Abort/reset: fft_done drops at bin 100 → scan_abort pulse, no result_valid. Separately, reset asserted during HOLD → all outputs 0 next edge, no fft_restart.
- FFT_PEAK_BITREV_EN build: nonzero word at stream position 0x102 (reversed = 0x081 = 129) → peak_bin=129. result_valid first high after edge N+READ_LATENCY+1.
